// File: rtl/gray_counter.sv
// Binary/Gray up counter with synchronous load, registered terminal-count pulse and async reset.
// Define GRAY_COUNTER_DOWN_EN to add the dir port and down counting.
module gray_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_COUNTER_DOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] binary,
  output logic [WIDTH-1:0] gray,
  output logic             tc
);

  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             tc_q, tc_d;
  logic             count_up;

`ifdef GRAY_COUNTER_DOWN_EN
  assign count_up = dir;
`else
  assign count_up = 1'b1;
`endif

  always_comb begin
    bin_d = bin_q;
    tc_d  = 1'b0;
    if (load) begin
      // A load never raises tc, even when it lands on a wrap value.
      bin_d = load_bin;
    end else if (en) begin
      if (count_up) begin
        bin_d = bin_q + WIDTH'(1);
        tc_d  = (bin_q == {WIDTH{1'b1}});
      end else begin
        bin_d = bin_q - WIDTH'(1);
        tc_d  = (bin_q == '0);
      end
    end
    // Gray is encoded from the next count so both flops update together.
    gray_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q  <= '0;
      gray_q <= '0;
      tc_q   <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      tc_q   <= tc_d;
    end
  end

  assign binary = bin_q;
  assign gray   = gray_q;
  assign tc     = tc_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=4); down-count scenario runs when
// GRAY_COUNTER_DOWN_EN is defined.
module tb_gray_counter;

  localparam int unsigned W = 4;

  typedef struct packed {
    logic [W-1:0] b;
    logic [W-1:0] g;
    logic         t;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [W-1:0] load_bin;
`ifdef GRAY_COUNTER_DOWN_EN
  logic         dir;
`endif
  logic [W-1:0] binary;
  logic [W-1:0] gray;
  logic         tc;

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] mb;
  int           n_checks = 0;
  int           n_pass   = 0;

  gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_bin (load_bin),
`ifdef GRAY_COUNTER_DOWN_EN
    .dir      (dir),
`endif
    .binary   (binary),
    .gray     (gray),
    .tc       (tc)
  );

  always #5 clk = ~clk;

  // Drive one cycle, push the model's expectation, advance to just after the edge.
  task automatic drive_step(input logic e_i, input logic l_i, input logic [W-1:0] lb_i);
    exp_t   x;
    logic   up;
    up = 1'b1;
`ifdef GRAY_COUNTER_DOWN_EN
    up = dir;
`endif
    en       = e_i;
    load     = l_i;
    load_bin = lb_i;
    x.t = 1'b0;
    if (l_i) begin
      x.b = lb_i;
    end else if (e_i) begin
      if (up) begin
        x.b = mb + 4'd1;
        x.t = (mb == 4'hf);
      end else begin
        x.b = mb - 4'd1;
        x.t = (mb == 4'h0);
      end
    end else begin
      x.b = mb;
    end
    x.g = x.b ^ (x.b >> 1);
    mb  = x.b;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({binary, gray, tc} !== {4'h0, 4'h0, 1'b0})
      $display("FAIL reset_state: got %b/%b/%b want 0000/0000/0", binary, gray, tc);
    else n_pass++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mb  = '0;
    for (int i = 0; i < 5; i++) begin
      drive_step(1'b1, 1'b0, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if ({binary, gray, tc} !== e)
        $display("FAIL reset_count%0d: got %b/%b/%b want %b/%b/%b", i, binary, gray, tc,
                 e.b, e.g, e.t);
      else n_pass++;
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({binary, gray, tc} !== {4'h0, 4'h0, 1'b0})
      $display("FAIL reset_async: got %b/%b/%b want 0000/0000/0", binary, gray, tc);
    else n_pass++;
    en = 1'b1; load = 1'b1; load_bin = 4'h9;
    @(posedge clk);
    #1;
    n_checks++;
    if ({binary, gray, tc} !== {4'h0, 4'h0, 1'b0})
      $display("FAIL reset_ignores_inputs: got %b/%b/%b want 0000/0000/0", binary, gray, tc);
    else n_pass++;
    rst = 1'b0;
    mb  = '0;
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'h1, 4'h1, 1'b0} || e !== {4'h1, 4'h1, 1'b0})
      $display("FAIL reset_first_step: got %b/%b/%b want 0001/0001/0", binary, gray, tc);
    else n_pass++;
  endtask

  task automatic test_up_sweep();
    logic [W-1:0] gtab [16];
    gtab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
             4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
`ifdef GRAY_COUNTER_DOWN_EN
    dir = 1'b1;
`endif
    drive_step(1'b0, 1'b1, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== e)
      $display("FAIL sweep_load0: got %b/%b/%b want %b/%b/%b", binary, gray, tc, e.b, e.g, e.t);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      drive_step(1'b1, 1'b0, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if ({binary, tc} !== {e.b, e.t} || gray !== gtab[i] || tc !== (i == 15))
        $display("FAIL sweep_step%0d: got %b/%b/%b want %b/%b/%b", i, binary, gray, tc,
                 e.b, gtab[i], (i == 15));
      else n_pass++;
    end
  endtask

  task automatic test_load_priority();
    drive_step(1'b1, 1'b1, 4'b1010);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b1010, 4'b1111, 1'b0} || e !== {4'b1010, 4'b1111, 1'b0})
      $display("FAIL load_priority: got %b/%b/%b want 1010/1111/0", binary, gray, tc);
    else n_pass++;
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b1011, 4'b1110, 1'b0} || e !== {4'b1011, 4'b1110, 1'b0})
      $display("FAIL load_then_step: got %b/%b/%b want 1011/1110/0", binary, gray, tc);
    else n_pass++;
  endtask

  task automatic test_hold();
    drive_step(1'b0, 1'b1, 4'b0111);
    void'(sb.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive_step(1'b0, 1'b0, 4'h0);
      e = sb.pop_front();
      n_checks++;
      if ({binary, gray, tc} !== {4'b0111, 4'b0100, 1'b0} || e !== {4'b0111, 4'b0100, 1'b0})
        $display("FAIL hold%0d: got %b/%b/%b want 0111/0100/0", i, binary, gray, tc);
      else n_pass++;
    end
  endtask

  task automatic test_load_max();
    drive_step(1'b0, 1'b1, 4'b1111);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b1111, 4'b1000, 1'b0} || e !== {4'b1111, 4'b1000, 1'b0})
      $display("FAIL load_max: got %b/%b/%b want 1111/1000/0", binary, gray, tc);
    else n_pass++;
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b0000, 4'b0000, 1'b1} || e !== {4'b0000, 4'b0000, 1'b1})
      $display("FAIL max_wrap: got %b/%b/%b want 0000/0000/1", binary, gray, tc);
    else n_pass++;
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b0001, 4'b0001, 1'b0})
      $display("FAIL tc_one_cycle: got %b/%b/%b want 0001/0001/0", binary, gray, tc);
    else n_pass++;
    // A load that lands on 0 from 1111 must not pulse tc.
    drive_step(1'b0, 1'b1, 4'b1111);
    void'(sb.pop_front());
    drive_step(1'b1, 1'b1, 4'b0000);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b0000, 4'b0000, 1'b0})
      $display("FAIL load_no_tc: got %b/%b/%b want 0000/0000/0", binary, gray, tc);
    else n_pass++;
  endtask

`ifdef GRAY_COUNTER_DOWN_EN
  task automatic test_down_wrap();
    dir = 1'b0;
    drive_step(1'b0, 1'b1, 4'b0001);
    void'(sb.pop_front());
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b0000, 4'b0000, 1'b0})
      $display("FAIL down_to_zero: got %b/%b/%b want 0000/0000/0", binary, gray, tc);
    else n_pass++;
    drive_step(1'b1, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b1111, 4'b1000, 1'b1})
      $display("FAIL down_wrap: got %b/%b/%b want 1111/1000/1", binary, gray, tc);
    else n_pass++;
    drive_step(1'b0, 1'b0, 4'h0);
    e = sb.pop_front();
    n_checks++;
    if ({binary, gray, tc} !== {4'b1111, 4'b1000, 1'b0})
      $display("FAIL down_tc_clear: got %b/%b/%b want 1111/1000/0", binary, gray, tc);
    else n_pass++;
    dir = 1'b1;
  endtask
`endif

  task automatic test_back_to_back();
    logic [W-1:0] prev_g;
    for (int i = 0; i < 60; i++) begin
      logic r_en, r_ld;
      r_en = 1'($urandom_range(0, 3) != 0);
      r_ld = 1'($urandom_range(0, 7) == 0);
`ifdef GRAY_COUNTER_DOWN_EN
      dir = 1'($urandom_range(0, 1));
`endif
      prev_g = mb ^ (mb >> 1);
      drive_step(r_en, r_ld, 4'($urandom));
      e = sb.pop_front();
      n_checks++;
      if ({binary, gray, tc} !== e ||
          (!r_ld && r_en && $countones(prev_g ^ e.g) != 1))
        $display("FAIL b2b%0d: got %b/%b/%b want %b/%b/%b", i, binary, gray, tc,
                 e.b, e.g, e.t);
      else n_pass++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_bin = '0;
`ifdef GRAY_COUNTER_DOWN_EN
    dir = 1'b1;
`endif
    mb = '0;
    #1;
    test_reset();
    test_up_sweep();
    test_load_priority();
    test_hold();
    test_load_max();
`ifdef GRAY_COUNTER_DOWN_EN
    test_down_wrap();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gray_counter.md
GRAY_COUNTER -- requirements
Module: gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (legal range 2..16).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port en  input  1  count enable; advances the count one step per cycle while high.
REQ-005 SHALL have port load  input  1  synchronous load strobe.
REQ-006 SHALL have port load_bin  input  WIDTH  binary value captured when load is high.
REQ-007 SHALL have port dir  input  1  count direction, 1 = up, 0 = down; present only when GRAY_COUNTER_DOWN_EN is defined.
REQ-008 SHALL have port binary  output  WIDTH  current count, binary, registered.
REQ-009 SHALL have port gray  output  WIDTH  current count, Gray coded, registered.
REQ-010 SHALL have port tc  output  1  terminal-count pulse, registered.

Function
REQ-011 SHALL keep an internal binary count register; binary SHALL equal that register.
REQ-012 SHALL drive gray from its own flop loaded with next_bin ^ (next_bin >> 1), so gray always equals binary ^ (binary >> 1) on the same cycle with no combinational path from inputs to gray.
REQ-013 SHALL give load priority over en: on a cycle with load=1, next_bin = load_bin regardless of en or dir.
REQ-014 SHALL, with load=0 and en=1, set next_bin = binary + 1 (up) or binary - 1 (down), modulo 2^WIDTH.
REQ-015 SHALL, with load=0 and en=0, hold binary, gray and drive tc=0.
REQ-016 SHALL wrap: up from 2^WIDTH-1 goes to 0; down from 0 goes to 2^WIDTH-1.
REQ-017 SHALL assert tc for exactly one cycle, in the cycle after a wrap step (registered with the new count), and never on a load, even if load_bin produces the same value.
REQ-018 SHALL guarantee successive gray values differ in exactly one bit for every count step, including wrap; a load may change any number of bits.
REQ-019 SHALL have latency one cycle from en/load sampled high to updated binary/gray/tc.
REQ-020 SHALL treat a dir change between cycles as taking effect on the next enabled step only; no extra or skipped step.

Reset
REQ-021 SHALL, while rst=1, force binary=0, gray=0, tc=0 immediately, independent of clk.
REQ-022 SHALL, on rst assertion mid-count or during load, discard the pending step/load; first step after deassertion starts from 0.
REQ-023 SHALL ignore en and load on any rising clk edge where rst is high.

Configuration
REQ-024 SHALL use macro GRAY_COUNTER_DOWN_EN to compile in the dir port and down-count logic.
REQ-025 SHALL, with GRAY_COUNTER_DOWN_EN undefined, omit dir and count up only; tc asserts only on the 2^WIDTH-1 -> 0 wrap.

Verification
REQ-026 SHALL test reset: rst=1 mid-count at binary=5 -> binary=0, gray=0000, tc=0 without waiting for clk.
REQ-027 SHALL test up sweep (WIDTH=4): en=1 for 16 cycles from 0 -> gray sequence 0000,0001,0011,0010,0110,...,1000,0000, one-bit changes each step, tc=1 only on the cycle gray returns to 0000.
REQ-028 SHALL test load priority: load=1, en=1, load_bin=1010 -> binary=1010, gray=1111, tc=0, next enabled step gives binary=1011, gray=1110.
REQ-029 SHALL test hold: en=0 for 5 cycles at binary=0111 -> binary=0111, gray=0100 unchanged, tc=0.
REQ-030 SHALL test down wrap (GRAY_COUNTER_DOWN_EN defined): dir=0, en=1 at binary=0001 -> 0000 then 1111 with gray=1000, tc=1 for one cycle.
REQ-031 SHALL test load to max: load_bin=1111 -> binary=1111, gray=1000, tc=0; next up step -> 0000, tc=1.
